// File: rtl/norm_cdf_pair.sv
// Paired standard-normal CDF evaluator: N(d1) and N(d2) in Q16.16.
// Each operand uses a 33-entry Phi table at a 0.25 step and linear interpolation.
module norm_cdf_pair #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] nd1,
  output logic [WIDTH-1:0] nd2,
  output logic             valid,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, ABS, LUT, MUL, ADD, DONE} state_t;

  // A table step of 0.25 puts the index at bit FBITS-2 of the magnitude.
  localparam int IW = FBITS - 2;
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) <<< FBITS;
  localparam logic signed [WIDTH-1:0] SAT_POS = WIDTH'(8) <<< FBITS;
  localparam logic signed [WIDTH-1:0] SAT_NEG = -SAT_POS;

  function automatic logic [16:0] t_rom(input logic [5:0] i);
    case (i)
      6'd0:    t_rom = 17'd32768;
      6'd1:    t_rom = 17'd39237;
      6'd2:    t_rom = 17'd45316;
      6'd3:    t_rom = 17'd50684;
      6'd4:    t_rom = 17'd55138;
      6'd5:    t_rom = 17'd58612;
      6'd6:    t_rom = 17'd61158;
      6'd7:    t_rom = 17'd62911;
      6'd8:    t_rom = 17'd64045;
      6'd9:    t_rom = 17'd64735;
      6'd10:   t_rom = 17'd65129;
      6'd11:   t_rom = 17'd65341;
      6'd12:   t_rom = 17'd65448;
      6'd13:   t_rom = 17'd65498;
      6'd14:   t_rom = 17'd65521;
      6'd15:   t_rom = 17'd65530;
      6'd16:   t_rom = 17'd65534;
      6'd17:   t_rom = 17'd65535;
      default: t_rom = 17'd65536;  // entries 18..32 all round to 1.0
    endcase
  endfunction

  state_t state_q, state_d;
  logic go_q, go_d, pass_q, pass_d, neg_q, neg_d, sat_q, sat_d, valid_q, valid_d;
  logic signed [WIDTH-1:0] x1_q, x1_d, x2_q, x2_d, p_q, p_d;
  logic signed [WIDTH-1:0] r0_q, r0_d, r1_q, r1_d, nd1_q, nd1_d, nd2_q, nd2_d;
  logic [FBITS+2:0] a_q, a_d;
  logic [16:0]      y0_q, y0_d, y1_q, y1_d;
  logic [IW-1:0]    frac_q, frac_d;

  logic signed [WIDTH-1:0] x_cur, diff, prod, y_sum, res;
  logic [4:0] idx;
  logic       accept;

  // go_q covers the cycle between acceptance and ABS so a second start is ignored.
  assign accept = start && (state_q == IDLE) && !go_q;

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      pass_q  <= 1'b0;
      neg_q   <= 1'b0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      x1_q    <= '0;
      x2_q    <= '0;
      a_q     <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      frac_q  <= '0;
      p_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      nd1_q   <= '0;
      nd2_q   <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      pass_q  <= pass_d;
      neg_q   <= neg_d;
      sat_q   <= sat_d;
      valid_q <= valid_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      a_q     <= a_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      frac_q  <= frac_d;
      p_q     <= p_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      nd1_q   <= nd1_d;
      nd2_q   <= nd2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go_q) state_d = ABS;
      ABS:     state_d = LUT;
      LUT:     state_d = MUL;
      MUL:     state_d = ADD;
      ADD:     state_d = pass_q ? DONE : ABS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path can infer a latch.
    go_d    = accept;
    pass_d  = pass_q;
    neg_d   = neg_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    x1_d    = x1_q;
    x2_d    = x2_q;
    a_d     = a_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    frac_d  = frac_q;
    p_d     = p_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    nd1_d   = nd1_q;
    nd2_d   = nd2_q;

    x_cur = pass_q ? x2_q : x1_q;
    idx   = a_q[FBITS+2:IW];
    diff  = WIDTH'(y1_q) - WIDTH'(y0_q);
    prod  = diff * $signed(WIDTH'(frac_q));
    y_sum = sat_q ? ONE : WIDTH'(y0_q) + p_q;
    res   = neg_q ? ONE - y_sum : y_sum;

    if (accept) begin
      x1_d = d1;
      x2_d = d2;
    end

    case (state_q)
      ABS: begin
        // Saturation is decided on signed x; only the in-range low bits need negating.
        neg_d = x_cur[WIDTH-1];
        sat_d = (x_cur >= SAT_POS) || (x_cur <= SAT_NEG);
        a_d   = x_cur[WIDTH-1] ? -x_cur[FBITS+2:0] : x_cur[FBITS+2:0];
      end
      LUT: begin
        y0_d   = t_rom({1'b0, idx});
        y1_d   = t_rom({1'b0, idx} + 6'd1);
        frac_d = a_q[IW-1:0];
      end
      MUL: p_d = prod >>> IW;
      ADD: begin
        if (pass_q) r1_d = res;
        else        r0_d = res;
        pass_d = ~pass_q;
      end
      DONE: begin
        nd1_d   = r0_q;
        nd2_d   = r1_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign nd1   = nd1_q;
  assign nd2   = nd2_q;
  assign valid = valid_q;
  assign busy  = go_q || (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_norm_cdf_pair.sv
// Directed and randomized checks of norm_cdf_pair against an arithmetic
// table-interpolation model of N(x).
module tb_norm_cdf_pair;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] d1, d2;
  logic [31:0] nd1, nd2;
  logic        valid, busy;

  int n_checks = 0;
  int n_errors = 0;

  int t_tab [33] = '{32768, 39237, 45316, 50684, 55138, 58612, 61158, 62911, 64045,
                     64735, 65129, 65341, 65448, 65498, 65521, 65530, 65534, 65535,
                     65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536, 65536,
                     65536, 65536, 65536, 65536, 65536, 65536};

  norm_cdf_pair #(.WIDTH(32), .FBITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .d1    (d1),
    .d2    (d2),
    .nd1   (nd1),
    .nd2   (nd2),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N(x) in Q16.16: interpolate between table points 0.25 apart, mirror for x < 0.
  function automatic int model(input int x);
    int a, i, f, y;
    if (x >= 8 * 65536 || x <= -8 * 65536) begin
      y = 65536;
    end else begin
      a = (x < 0) ? -x : x;
      i = a / 16384;
      f = a % 16384;
      y = t_tab[i] + ((t_tab[i+1] - t_tab[i]) * f) / 16384;
    end
    return (x < 0) ? 65536 - y : y;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start for exactly one sampling edge (edge k); returns 1 time unit after it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    d1    = a;
    d2    = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Edges after the reference edge until valid is seen; -1 if the bound expires.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    issue(a, b);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check({tag, "_lat"}, lat, 32'd10);
    check({tag, "_nd1"}, nd1, model(int'(a)));
    check({tag, "_nd2"}, nd2, model(int'(b)));
  endtask

  initial begin
    int lat, seen, x, delta;
    reset = 1'b0;
    start = 1'b1;
    d1    = 32'h0001_0000;
    d2    = 32'h0002_0000;

    // Reset state, with start held during reset.
    repeat (3) step();
    check("rst_nd1", nd1, 32'd0);
    check("rst_nd2", nd2, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid === 1'b1 || busy === 1'b1) seen++;
    end
    check("rst_start_ignored", seen, 32'd0);

    // Known-value pairs.
    run_pair("zero_one", 32'h0000_0000, 32'h0001_0000);
    check("zero_one_nd1_abs", nd1, 32'd32768);
    check("zero_one_nd2_abs", nd2, 32'd55138);
    step();
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    check("busy_falls", {31'd0, busy}, 32'd0);
    repeat (4) step();
    check("hold_nd1", nd1, 32'd32768);
    check("hold_nd2", nd2, 32'd55138);

    run_pair("neg1_eighth", 32'hFFFF_0000, 32'h0000_2000);
    check("neg1_eighth_nd1_abs", nd1, 32'd10398);
    check("neg1_eighth_nd2_abs", nd2, 32'd36002);

    run_pair("sat9_min", 32'h0009_0000, 32'h8000_0000);
    check("sat9_nd1_abs", nd1, 32'd65536);
    check("min_nd2_abs", nd2, 32'd0);

    run_pair("sat8_edge", 32'h0008_0000, 32'hFFF8_0000);
    check("sat8_nd1_abs", nd1, 32'd65536);
    check("satm8_nd2_abs", nd2, 32'd0);

    run_pair("near8", 32'h0007_FFFF, 32'hFFF8_0001);

    // Start during busy is ignored; back-to-back start on the valid cycle is accepted.
    issue(32'h0000_8000, 32'hFFFF_8000);
    step();
    step();
    d1    = 32'h0003_0000;
    d2    = 32'h0004_0000;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(lat);
    check("ignore_lat", lat, 32'd7);
    check("ignore_nd1", nd1, model(int'(32'h0000_8000)));
    check("ignore_nd2", nd2, model(int'(32'hFFFF_8000)));
    issue(32'hFFFE_4000, 32'h0002_C000);
    check("b2b_valid_drop", {31'd0, valid}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid(lat);
    check("b2b_lat", lat, 32'd10);
    check("b2b_nd1", nd1, model(int'(32'hFFFE_4000)));
    check("b2b_nd2", nd2, model(int'(32'h0002_C000)));

    // Reset mid-computation aborts without a valid pulse.
    step();
    issue(32'h0001_0000, 32'h0002_0000);
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_nd1", nd1, 32'd0);
    check("abort_nd2", nd2, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
    run_pair("after_abort", 32'hFFFF_C000, 32'h0001_4000);

    // Random sweep: even trials test symmetry, odd trials test monotonicity.
    for (int t = 0; t < 1500; t++) begin
      x = int'($urandom_range(18 * 65536)) - 9 * 65536;
      if (t % 2 == 0) begin
        run_pair("rnd_sym", x, -x);
        check("rnd_sym_sum", nd1 + nd2, 32'd65536);
      end else begin
        delta = int'($urandom_range(4096, 1));
        run_pair("rnd_mono", x, x + delta);
        check("rnd_mono_order", {31'd0, (nd2 >= nd1)}, 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
